// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v scan counters, sync/blank decode
// and an IDLE/RUN/DRAIN controller that only stops scanning at a frame boundary.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DIV      = 4,
  parameter int XY_W     = 10,
  parameter int FC_W     = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  output logic            pix_tick,
  output logic            hsync,
  output logic            vsync,
  output logic            video_on,
  output logic [XY_W-1:0] pixel_x,
  output logic [XY_W-1:0] pixel_y,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_cnt,
  output logic            busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0]   D_LAST = DW'(DIV - 1);
  localparam logic [XY_W-1:0] H_LAST = XY_W'(H_TOTAL - 1);
  localparam logic [XY_W-1:0] V_LAST = XY_W'(V_TOTAL - 1);
  localparam logic [XY_W-1:0] H_VIS  = XY_W'(H_ACTIVE);
  localparam logic [XY_W-1:0] V_VIS  = XY_W'(V_ACTIVE);
  localparam logic [XY_W-1:0] HS_B   = XY_W'(H_ACTIVE + H_FP);
  localparam logic [XY_W-1:0] HS_E   = XY_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XY_W-1:0] VS_B   = XY_W'(V_ACTIVE + V_FP);
  localparam logic [XY_W-1:0] VS_E   = XY_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   d, d_nxt;
  logic [XY_W-1:0] h, v, h_nxt, v_nxt;
  logic [FC_W-1:0] fc_nxt;
  logic            tick, eol, eof, act_nxt, lstart, fstart;

  assign pixel_x = h;
  assign pixel_y = v;

  always_comb begin
    state_nxt = state;
    d_nxt     = d;
    h_nxt     = h;
    v_nxt     = v;
    fc_nxt    = frame_cnt;
    tick      = (state != IDLE) && (d == D_LAST);
    eol       = 1'b0;
    eof       = 1'b0;
    lstart    = 1'b0;
    fstart    = 1'b0;
    case (state)
      IDLE: begin
        d_nxt = '0;
        h_nxt = '0;
        v_nxt = '0;
        if (run) begin
          state_nxt = RUN;
          lstart    = 1'b1;
          fstart    = 1'b1;
        end
      end
      default: begin
        d_nxt = tick ? '0 : d + 1'b1;
        if (tick) begin
          if (h == H_LAST) begin
            h_nxt = '0;
            eol   = 1'b1;
            if (v == V_LAST) begin
              v_nxt  = '0;
              eof    = 1'b1;
              fc_nxt = frame_cnt + 1'b1;
            end else begin
              v_nxt = v + 1'b1;
            end
          end else begin
            h_nxt = h + 1'b1;
          end
        end
        // run wins over the drain exit, so a re-raise at end of frame wraps normally
        if (run)                       state_nxt = RUN;
        else if (state == DRAIN && eof) state_nxt = IDLE;
        else                           state_nxt = DRAIN;
        lstart = eol && (state_nxt != IDLE);
        fstart = eof && (state_nxt != IDLE);
      end
    endcase
    act_nxt = (state_nxt != IDLE);
  end

  // Outputs decode the next counter values so they line up with pixel_x/pixel_y.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      d           <= '0;
      h           <= '0;
      v           <= '0;
      frame_cnt   <= '0;
      pix_tick    <= 1'b0;
      video_on    <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      d           <= d_nxt;
      h           <= h_nxt;
      v           <= v_nxt;
      frame_cnt   <= fc_nxt;
      pix_tick    <= act_nxt && (d_nxt == D_LAST);
      video_on    <= act_nxt && (h_nxt < H_VIS) && (v_nxt < V_VIS);
      hsync       <= (act_nxt && h_nxt >= HS_B && h_nxt < HS_E) ? HS_POL : ~HS_POL;
      vsync       <= (act_nxt && v_nxt >= VS_B && v_nxt < VS_E) ? VS_POL : ~VS_POL;
      line_start  <= lstart;
      frame_start <= fstart;
      busy        <= act_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster, random run/reset activity, outputs compared
// every clock against a model that derives the raster from an absolute clock count.
module tb_vga_timing_gen;
  localparam int HA = 6, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int DIV = 2, XY = 6, FC = 3;
  localparam bit HP = 1'b1, VP = 1'b0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int FCLK = FR * DIV;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          run   = 1'b0;
  logic          pix_tick, hsync, vsync, video_on, line_start, frame_start, busy;
  logic [XY-1:0] pixel_x, pixel_y;
  logic [FC-1:0] frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .DIV(DIV), .XY_W(XY), .FC_W(FC)
  ) dut (
    .clock(clock), .reset(reset), .run(run),
    .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clock = ~clock;

  int nchk = 0, npass = 0;
  // model: k = clocks since the current frame began, act = scanning, drn = run was low
  int k = 0, fc = 0;
  bit act = 1'b0, drn = 1'b0;

  task automatic chk(input string tag, input longint got, input longint exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge(input bit r, input bit rs);
    bit tick, endf;
    if (rs) begin
      act = 0; drn = 0; k = 0; fc = 0;
    end else if (!act) begin
      if (r) begin act = 1; drn = 0; k = 0; end
    end else begin
      tick = (k % DIV) == DIV - 1;
      endf = tick && (k / DIV) == FR - 1;
      if (endf) fc = (fc + 1) % (1 << FC);
      if (endf && drn && !r) begin
        act = 0; drn = 0; k = 0;
      end else begin
        k   = (k + 1) % FCLK;
        drn = !r;
      end
    end
  endtask

  task automatic check_outs();
    int pos, h, v, ph;
    pos = k / DIV;
    ph  = k % DIV;
    h   = act ? pos % HT : 0;
    v   = act ? pos / HT : 0;
    chk("pixel_x",     pixel_x,     h);
    chk("pixel_y",     pixel_y,     v);
    chk("busy",        busy,        act);
    chk("frame_cnt",   frame_cnt,   fc);
    chk("pix_tick",    pix_tick,    act && ph == DIV - 1);
    chk("video_on",    video_on,    act && h < HA && v < VA);
    chk("hsync",       hsync,       (act && h >= HA + HF && h < HA + HF + HS) ? HP : !HP);
    chk("vsync",       vsync,       (act && v >= VA + VF && v < VA + VF + VS) ? VP : !VP);
    chk("line_start",  line_start,  act && h == 0 && ph == 0);
    chk("frame_start", frame_start, act && pos == 0 && ph == 0);
  endtask

  task automatic step(input bit r, input bit rs);
    reset = rs;
    run   = r;
    @(posedge clock);
    model_edge(r, rs);
    #1;
    check_outs();
  endtask

  initial begin
    bit r;
    step(0, 1);
    step(0, 1);
    repeat (5) step(0, 0);
    // continuous run long enough for frame_cnt to wrap
    repeat (FCLK * 9 + 37) step(1, 0);
    // drop run mid-frame and let it drain to idle
    repeat (FCLK + 20) step(0, 0);
    // drain re-entry mid-frame
    repeat (FCLK / 2 + 3) step(1, 0);
    repeat (FCLK / 3) step(0, 0);
    repeat (FCLK * 2) step(1, 0);
    // reset mid-frame aborts immediately
    repeat (77) step(1, 0);
    step(1, 1);
    step(0, 0);
    step(1, 0);
    repeat (FCLK / 2) step(1, 0);
    // random run toggling with rare resets
    r = 1'b1;
    for (int i = 0; i < 9000; i++) begin
      if ($urandom_range(249) == 0) r = ~r;
      step(r, $urandom_range(2999) == 0);
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), SHALL be honoured as listed:
- H_ACTIVE 640: visible pixels per line.
- H_FP 16: horizontal front porch, in pixels.
- H_SYNC 96: hsync width, in pixels.
- H_BP 48: horizontal back porch, in pixels.
- V_ACTIVE 480: visible lines per frame.
- V_FP 10: vertical front porch, in lines.
- V_SYNC 2: vsync width, in lines.
- V_BP 33: vertical back porch, in lines.
- HS_POL 0: hsync active level.
- VS_POL 0: vsync active level.
- DIV 4: system clocks per pixel, must be at least 1.
- XY_W 10: width of the pixel counters.
- FC_W 16: width of the frame counter.

REQ-002 Ports (name, direction, width, meaning), SHALL be exactly:
- clock, in, 1: the single clock.
- reset, in, 1: synchronous, active-high reset.
- run, in, 1: request scanning.
- pix_tick, out, 1: pixel-rate enable.
- hsync, out, 1: horizontal sync.
- vsync, out, 1: vertical sync.
- video_on, out, 1: visible region.
- pixel_x, out, XY_W: horizontal counter.
- pixel_y, out, XY_W: vertical counter.
- line_start, out, 1: line start pulse.
- frame_start, out, 1: frame start pulse.
- frame_cnt, out, FC_W: completed frame count.
- busy, out, 1: state is not IDLE.

REQ-003 The block SHALL use one clock, named clock, with reset named reset; reset SHALL be synchronous and active-high.

Function
REQ-004 Totals SHALL be H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-005 The block SHALL hold internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1); pixel_x SHALL equal h and pixel_y SHALL equal v at all times.
REQ-006 The divider d SHALL count 0..DIV-1 only outside IDLE.
- pix_tick SHALL be 1 for exactly one clock when d==DIV-1.
- With DIV=1, pix_tick SHALL be 1 on every clock outside IDLE.
REQ-007 On each clock with pix_tick=1, h SHALL increment.
- At H_TOTAL-1, h SHALL wrap to 0 and v SHALL increment.
- At V_TOTAL-1, v SHALL wrap to 0 and frame_cnt SHALL increment, wrapping modulo 2^FC_W.
REQ-008 All outputs SHALL be registered and SHALL decode the current h/v with zero skew.
- video_on SHALL be 1 when h<H_ACTIVE and v<V_ACTIVE.
- hsync SHALL be HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, and ~HS_POL otherwise.
- vsync SHALL use the same rule on v with VS_POL.
REQ-009 Pulse outputs SHALL be one clock wide.
- line_start SHALL pulse on the clock edge at which h becomes 0.
- frame_start SHALL pulse on the clock edge at which h and v both become 0, including entry from IDLE.
REQ-010 The state machine SHALL have the states IDLE, RUN and DRAIN.
- IDLE: h=v=d=0, video_on=0, syncs inactive, no pulses.
- IDLE with run=1: next edge SHALL go to RUN, with pixel (0,0) presented and line_start=frame_start=1 on that edge.
- RUN with run=0: next edge SHALL go to DRAIN; counting continues.
- DRAIN with run=1: next edge SHALL go to RUN with no timing discontinuity.
- DRAIN, on the pix_tick where h=H_TOTAL-1 and v=V_TOTAL-1: SHALL go to IDLE; counters SHALL clear; frame_cnt SHALL increment; frame_start SHALL NOT pulse.
- If run=1 at that same end-of-frame tick, the RUN rule SHALL take priority and the frame SHALL wrap normally.
REQ-011 busy SHALL be 0 in IDLE and 1 in RUN and DRAIN.
REQ-012 Frames SHALL never be truncated by run: deassertion SHALL only take effect at a frame boundary.

Reset
REQ-013 reset=1 SHALL take priority over run and all counting.
REQ-014 On the edge where reset=1, the block SHALL enter IDLE with:
- h=v=d=0 and frame_cnt=0.
- pix_tick=video_on=line_start=frame_start=busy=0.
- hsync=~HS_POL and vsync=~VS_POL.
REQ-015 Reset asserted mid-frame SHALL abort the frame immediately, with no drain.

Verification
REQ-016 Default parameters: reset, then run=1 held. Required response:
- frame_start at the first edge.
- pix_tick every 4th clock.
- frame_start period of 1,680,000 clocks.
- frame_cnt=1 after the first wrap.
REQ-017 Default parameters, hsync check: hsync=0 exactly for h in 656..751, 96 ticks per line; hsync=1 elsewhere. vsync=0 exactly for v in 490..491.
REQ-018 Default parameters, video_on check: video_on=1 for 640x480 = 307,200 ticks per frame; line_start pulses 525 times per frame.
REQ-019 Drop run at h=100, v=200. Required response:
- Scanning continues to h=799, v=524.
- Then IDLE with busy=0 and frame_cnt incremented.
- No frame_start pulse at the exit.
REQ-020 Drain re-entry: drop run, then re-raise it at v=300. Required response: no gap in the timing, and the next frame_start occurs on time.
REQ-021 Parameters H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1, DIV=1, HS_POL=1:
- The frame SHALL be 35 clocks.
- hsync=1 only at h=5.
- Reset at h=3 SHALL give the REQ-014 values on the next edge.
